id_ex_pipe_ctrl: RTL and testbench
==================================

// Module: id_ex_pipe_ctrl
// PURPOSE
//  Parametrised ID/EX pipeline register for the MIPS core, with a built-in load-use
//  interlock FSM, flush (taken jump/branch) squash, external stall hold, and saturating
//  stall/flush counters. Sits between decode (control unit + register bank) and EX.
//  Supersedes the fixed-width ID latch: adds valid tracking and multi-cycle load interlock.
// PARAMETERS
//  DATA_W   32     width of PC and sign-extended immediate
//  REG_AW   5      register address width; address 0 is hard-wired zero, never a hazard
//  CTRL_W   16     width of packed control bundle (aluOp, wbi, memWrite, datasize, ...)
//  CTRL_NOP 16'h0  control value loaded on bubble/flush/reset (no write, no mem access)
//  LU_STALL 1      bubbles inserted per load-use hazard (1..7)
//  CNT_W    16     width of the performance counters
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high reset
//  flush        in   1       squash the instruction in ID (taken jump/branch)
//  ext_stall    in   1       downstream stall: freeze all state
//  id_valid     in   1       ID holds a real instruction (0 = nop from IF)
//  id_pc        in   DATA_W  PC of instruction in ID
//  id_ctrl      in   CTRL_W  decoded control bundle
//  id_mem_read  in   1       instruction in ID is a load
//  id_imm       in   DATA_W  sign-extended immediate
//  id_rs        in   REG_AW  source reg 1; id_rt: source reg 2 (same width)
//  id_rd        in   REG_AW  destination register (after regDst mux)
//  id_use_rs    in   1       instruction reads rs; id_use_rt: reads rt
//  ex_valid     out  1       EX slot holds a real instruction
//  ex_pc, ex_imm out DATA_W  registered PC / immediate
//  ex_ctrl      out  CTRL_W  registered control bundle
//  ex_mem_read  out  1       EX holds a load
//  ex_rs, ex_rt, ex_rd out REG_AW  registered register addresses
//  hold_if      out  1       freeze PC and IF/ID (combinational)
//  stall_cnt    out  CNT_W   cycles spent in load-use interlock (saturating)
//  flush_cnt    out  CNT_W   flush events taken (saturating)
// BEHAVIOUR
//  Reset (async): ex_valid=0, ex_ctrl=CTRL_NOP, all other ex_* =0, FSM=RUN, counters=0.
//  hazard = id_valid & ex_valid & ex_mem_read & ex_rd!=0 &
//           ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
//  hold_if = (state==RUN & hazard & !flush) | state==LOCK; also high whenever ext_stall.
//  Per-edge priority: flush > ext_stall > interlock > load.
//   flush: EX <= bubble (valid=0, ctrl=CTRL_NOP, rest 0); FSM->RUN, bubble cnt=0; flush_cnt++.
//   ext_stall (no flush): every register incl. FSM and bubble counter holds.
//   RUN & hazard: EX <= bubble; if LU_STALL>1 go LOCK with cnt=LU_STALL-1; stall_cnt++.
//   LOCK: EX <= bubble; cnt--; return RUN when cnt reaches 0; stall_cnt++ each cycle.
//   otherwise: EX <= ID fields, ex_valid<=id_valid; ex_ctrl<=id_valid?id_ctrl:CTRL_NOP.
//  Latency 1 cycle ID->EX. On return to RUN the instruction still held in ID loads normally
//  (load has left EX, so hazard is false).
//  Counters saturate at all-ones, never wrap. Flush during LOCK aborts interlock at once.
// TESTING
//  1 reset mid-stream: assert reset between edges -> outputs 0/CTRL_NOP immediately, cnt=0.
//  2 lw $5 then add $6,$5,$7, LU_STALL=1 -> hold_if=1 one cycle, one bubble, add in EX next.
//  3 LU_STALL=3, lw $4 then use $4 as rt -> 3 bubbles, stall_cnt=3, then consumer enters EX.
//  4 lw $0 then use $0 -> no hazard, hold_if=0, consumer follows back-to-back.
//  5 flush in 2nd LOCK cycle -> EX bubble, FSM RUN, flush_cnt=1, hold_if drops same cycle.
//  6 ext_stall 4 cycles during LOCK -> EX and bubble count frozen; CNT_W=2 counters stop at 3.

Source files
------------

// File: rtl/id_ex_pipe_ctrl.sv
// id_ex_pipe_ctrl: ID/EX pipeline register with load-use interlock, flush squash, stall hold and perf counters
module id_ex_pipe_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 16,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter int LU_STALL = 1,
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              ext_stall,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              hold_if,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    typedef enum logic {RUN, LOCK} fsmState;
    fsmState state;
    logic [2:0] bubbleCnt;
    logic hazard, takeId, advance;
    assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                    ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
    assign hold_if = ext_stall | (state == LOCK) | ((state == RUN) & hazard & ~flush);
    assign takeId = (state == RUN) & ~hazard & ~flush;
    assign advance = flush | ~ext_stall;
    // EX slot: load the ID instruction or insert a bubble; frozen under external stall
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= CTRL_NOP;
            ex_mem_read <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
        end else if (advance) begin
            ex_valid    <= takeId & id_valid;
            ex_ctrl     <= (takeId & id_valid) ? id_ctrl : CTRL_NOP;
            ex_mem_read <= takeId & id_mem_read;
            ex_pc       <= takeId ? id_pc : '0;
            ex_imm      <= takeId ? id_imm : '0;
            ex_rs       <= takeId ? id_rs : '0;
            ex_rt       <= takeId ? id_rt : '0;
            ex_rd       <= takeId ? id_rd : '0;
        end
    end
    // Interlock FSM with remaining-bubble count, plus saturating stall/flush counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            bubbleCnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            state     <= RUN;
            bubbleCnt <= '0;
            if (!(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
        end else if (!ext_stall) begin
            if (state == LOCK) begin
                bubbleCnt <= bubbleCnt - 3'd1;
                if (bubbleCnt == 3'd1) state <= RUN;
            end else if (hazard && LU_STALL > 1) begin
                state     <= LOCK;
                bubbleCnt <= 3'(LU_STALL - 1);
            end
            if (((state == LOCK) || hazard) && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_ex_pipe_ctrl.sv
// tb_id_ex_pipe_ctrl: directed tests for the ID/EX register, interlock, flush, stall and counters
module tb_id_ex_pipe_ctrl;
    localparam logic [15:0] NOPB = 16'h00F0;
    logic clock = 1'b0, reset = 1'b1, flush = 1'b0, ext_stall = 1'b0;
    logic idValid = 1'b0, idMemRead = 1'b0, idUseRs = 1'b0, idUseRt = 1'b0;
    logic [31:0] idPc = '0, idImm = '0;
    logic [15:0] idCtrl = '0;
    logic [4:0] idRs = '0, idRt = '0, idRd = '0;
    logic aExValid, aExMemRead, aHoldIf, bExValid, bExMemRead, bHoldIf;
    logic [31:0] aExPc, aExImm, bExPc, bExImm;
    logic [15:0] aExCtrl, bExCtrl, aStallCnt, aFlushCnt;
    logic [1:0] bStallCnt, bFlushCnt;
    logic [4:0] aExRs, aExRt, aExRd, bExRs, bExRt, bExRd;
    int nChecks = 0, nFails = 0;

    always #5 clock = ~clock;

    id_ex_pipe_ctrl #(.LU_STALL(1), .CNT_W(16)) dutA (
        .clock(clock), .reset(reset), .flush(flush), .ext_stall(ext_stall), .id_valid(idValid),
        .id_pc(idPc), .id_ctrl(idCtrl), .id_mem_read(idMemRead), .id_imm(idImm), .id_rs(idRs),
        .id_rt(idRt), .id_rd(idRd), .id_use_rs(idUseRs), .id_use_rt(idUseRt), .ex_valid(aExValid),
        .ex_pc(aExPc), .ex_imm(aExImm), .ex_ctrl(aExCtrl), .ex_mem_read(aExMemRead), .ex_rs(aExRs),
        .ex_rt(aExRt), .ex_rd(aExRd), .hold_if(aHoldIf), .stall_cnt(aStallCnt), .flush_cnt(aFlushCnt));

    id_ex_pipe_ctrl #(.CTRL_NOP(NOPB), .LU_STALL(3), .CNT_W(2)) dutB (
        .clock(clock), .reset(reset), .flush(flush), .ext_stall(ext_stall), .id_valid(idValid),
        .id_pc(idPc), .id_ctrl(idCtrl), .id_mem_read(idMemRead), .id_imm(idImm), .id_rs(idRs),
        .id_rt(idRt), .id_rd(idRd), .id_use_rs(idUseRs), .id_use_rt(idUseRt), .ex_valid(bExValid),
        .ex_pc(bExPc), .ex_imm(bExImm), .ex_ctrl(bExCtrl), .ex_mem_read(bExMemRead), .ex_rs(bExRs),
        .ex_rt(bExRt), .ex_rd(bExRd), .hold_if(bHoldIf), .stall_cnt(bStallCnt), .flush_cnt(bFlushCnt));

    function automatic logic [15:0] ctrlOf(input logic [31:0] pc);
        return {pc[7:0], 8'h3C};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic mr, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic urs, input logic urt, input logic [31:0] pc);
        idValid = v; idMemRead = mr; idRs = rs; idRt = rt; idRd = rd;
        idUseRs = urs; idUseRt = urt; idPc = pc; idCtrl = ctrlOf(pc); idImm = pc ^ 32'h0000_8000;
        #1;
    endtask

    task automatic doReset;
        flush = 1'b0; ext_stall = 1'b0; reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        nChecks++; if (aExValid !== 1'b0) begin nFails++; $display("FAIL reset_a_valid got %0h want 0", aExValid); end
        nChecks++; if (aExCtrl !== 16'h0) begin nFails++; $display("FAIL reset_a_ctrl got %0h want 0", aExCtrl); end
        nChecks++; if (bExCtrl !== NOPB) begin nFails++; $display("FAIL reset_b_ctrl got %0h want %0h", bExCtrl, NOPB); end
        nChecks++; if (aExPc !== 32'h0) begin nFails++; $display("FAIL reset_a_pc got %0h want 0", aExPc); end
        nChecks++; if (aStallCnt !== 16'h0 || aFlushCnt !== 16'h0) begin nFails++; $display("FAIL reset_cnt got %0h/%0h want 0/0", aStallCnt, aFlushCnt); end
        nChecks++; if (aHoldIf !== 1'b0) begin nFails++; $display("FAIL reset_hold got %0h want 0", aHoldIf); end
    endtask

    task automatic test_load_use;
        doReset;
        drive(1, 1, 1, 5, 5, 1, 0, 32'h100);
        tick;
        nChecks++; if (aExValid !== 1'b1 || aExMemRead !== 1'b1 || aExRd !== 5'd5) begin nFails++; $display("FAIL lu_load got v%0h mr%0h rd%0d want 1 1 5", aExValid, aExMemRead, aExRd); end
        drive(1, 0, 5, 7, 6, 1, 1, 32'h104);
        nChecks++; if (aHoldIf !== 1'b1) begin nFails++; $display("FAIL lu_hold got %0h want 1", aHoldIf); end
        tick;
        nChecks++; if (aExValid !== 1'b0 || aExCtrl !== 16'h0) begin nFails++; $display("FAIL lu_bubble got v%0h c%0h want 0 0", aExValid, aExCtrl); end
        nChecks++; if (aStallCnt !== 16'd1) begin nFails++; $display("FAIL lu_stallcnt got %0d want 1", aStallCnt); end
        nChecks++; if (aHoldIf !== 1'b0) begin nFails++; $display("FAIL lu_hold_drop got %0h want 0", aHoldIf); end
        tick;
        nChecks++; if (aExValid !== 1'b1 || aExPc !== 32'h104 || aExRd !== 5'd6) begin nFails++; $display("FAIL lu_consumer got v%0h pc%0h rd%0d want 1 104 6", aExValid, aExPc, aExRd); end
        nChecks++; if (aExCtrl !== ctrlOf(32'h104) || aExImm !== 32'h8104) begin nFails++; $display("FAIL lu_fields got c%0h i%0h want %0h 8104", aExCtrl, aExImm, ctrlOf(32'h104)); end
    endtask

    task automatic test_multi_stall;
        doReset;
        drive(1, 1, 2, 4, 4, 1, 0, 32'h200);
        tick;
        drive(1, 0, 3, 4, 8, 1, 1, 32'h204);
        nChecks++; if (bHoldIf !== 1'b1) begin nFails++; $display("FAIL ms_hold0 got %0h want 1", bHoldIf); end
        for (int i = 1; i <= 3; i++) begin
            tick;
            nChecks++; if (bExValid !== 1'b0 || bExCtrl !== NOPB) begin nFails++; $display("FAIL ms_bubble%0d got v%0h c%0h want 0 %0h", i, bExValid, bExCtrl, NOPB); end
            nChecks++; if (bHoldIf !== (i < 3)) begin nFails++; $display("FAIL ms_hold%0d got %0h want %0h", i, bHoldIf, i < 3); end
        end
        nChecks++; if (bStallCnt !== 2'd3) begin nFails++; $display("FAIL ms_stallcnt got %0d want 3", bStallCnt); end
        tick;
        nChecks++; if (bExValid !== 1'b1 || bExPc !== 32'h204 || bExRt !== 5'd4) begin nFails++; $display("FAIL ms_consumer got v%0h pc%0h rt%0d want 1 204 4", bExValid, bExPc, bExRt); end
    endtask

    task automatic test_zero_reg;
        doReset;
        drive(1, 1, 1, 0, 0, 1, 0, 32'h300);
        tick;
        drive(1, 0, 0, 0, 9, 1, 1, 32'h304);
        nChecks++; if (aHoldIf !== 1'b0 || bHoldIf !== 1'b0) begin nFails++; $display("FAIL zr_hold got %0h/%0h want 0/0", aHoldIf, bHoldIf); end
        tick;
        nChecks++; if (aExValid !== 1'b1 || aExPc !== 32'h304 || aStallCnt !== 16'd0) begin nFails++; $display("FAIL zr_follow got v%0h pc%0h s%0d want 1 304 0", aExValid, aExPc, aStallCnt); end
    endtask

    task automatic test_flush_lock;
        doReset;
        drive(1, 1, 2, 4, 4, 1, 0, 32'h400);
        tick;
        drive(1, 0, 4, 1, 8, 1, 0, 32'h404);
        tick;
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
        nChecks++; if (bExValid !== 1'b0 || bFlushCnt !== 2'd1 || bStallCnt !== 2'd2) begin nFails++; $display("FAIL fl_state got v%0h f%0d s%0d want 0 1 2", bExValid, bFlushCnt, bStallCnt); end
        nChecks++; if (bHoldIf !== 1'b0) begin nFails++; $display("FAIL fl_hold got %0h want 0", bHoldIf); end
        drive(1, 0, 1, 2, 3, 1, 1, 32'h408);
        tick;
        nChecks++; if (bExValid !== 1'b1 || bExPc !== 32'h408) begin nFails++; $display("FAIL fl_resume got v%0h pc%0h want 1 408", bExValid, bExPc); end
    endtask

    task automatic test_ext_stall;
        doReset;
        drive(1, 1, 2, 4, 4, 1, 0, 32'h500);
        tick;
        drive(1, 0, 4, 1, 8, 1, 0, 32'h504);
        tick;
        ext_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            nChecks++; if (bExValid !== 1'b0 || bStallCnt !== 2'd1 || bHoldIf !== 1'b1) begin nFails++; $display("FAIL es_frozen%0d got v%0h s%0d h%0h want 0 1 1", i, bExValid, bStallCnt, bHoldIf); end
        end
        ext_stall = 1'b0;
        tick;
        tick;
        nChecks++; if (bStallCnt !== 2'd3 || bHoldIf !== 1'b0) begin nFails++; $display("FAIL es_release got s%0d h%0h want 3 0", bStallCnt, bHoldIf); end
        tick;
        nChecks++; if (bExValid !== 1'b1 || bExPc !== 32'h504) begin nFails++; $display("FAIL es_consumer got v%0h pc%0h want 1 504", bExValid, bExPc); end
        drive(1, 1, 2, 4, 4, 1, 0, 32'h508);
        tick;
        drive(1, 0, 4, 1, 8, 1, 0, 32'h50C);
        for (int i = 0; i < 4; i++) tick;
        nChecks++; if (bStallCnt !== 2'd3) begin nFails++; $display("FAIL es_stall_sat got %0d want 3", bStallCnt); end
        flush = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        flush = 1'b0;
        nChecks++; if (bFlushCnt !== 2'd3 || aFlushCnt !== 16'd4) begin nFails++; $display("FAIL es_flush_sat got %0d/%0d want 3/4", bFlushCnt, aFlushCnt); end
    endtask

    task automatic test_reset_midstream;
        drive(1, 1, 1, 2, 3, 1, 1, 32'h600);
        tick;
        nChecks++; if (aExValid !== 1'b1 || aExPc !== 32'h600) begin nFails++; $display("FAIL mr_pre got v%0h pc%0h want 1 600", aExValid, aExPc); end
        #2;
        reset = 1'b1;
        #1;
        nChecks++; if (aExValid !== 1'b0 || aExPc !== 32'h0 || aExCtrl !== 16'h0 || aExMemRead !== 1'b0) begin nFails++; $display("FAIL mr_ex got v%0h pc%0h c%0h mr%0h want 0 0 0 0", aExValid, aExPc, aExCtrl, aExMemRead); end
        nChecks++; if (bExCtrl !== NOPB || bExRd !== 5'd0) begin nFails++; $display("FAIL mr_b got c%0h rd%0d want %0h 0", bExCtrl, bExRd, NOPB); end
        nChecks++; if (aStallCnt !== 16'd0 || aFlushCnt !== 16'd0 || bFlushCnt !== 2'd0) begin nFails++; $display("FAIL mr_cnt got %0d %0d %0d want 0 0 0", aStallCnt, aFlushCnt, bFlushCnt); end
        tick;
        reset = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        test_reset;
        reset = 1'b0;
        test_load_use;
        test_multi_stall;
        test_zero_reg;
        test_flush_lock;
        test_ext_stall;
        test_reset_midstream;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
